input_event_conditioner: RTL and testbench

//  - Front end of the control FSMs: conditions raw, asynchronous button/sensor lines into clean debounced levels
//    and one event token per qualified edge.
//  - The downstream Moore FSM consumes evt_valid/evt_chan as its next-state inputs (arm, disarm, trigger).
//  - Removes metastability, contact bounce and multi-cycle pulses, so the FSM sees exactly one event per press.

---
 rtl/input_event_conditioner.sv | 166 ++++++++++++++++
 tb/tb_input_event_conditioner.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_event_conditioner.sv
// input_event_conditioner: 2-FF sync + per-channel debounce + one token per qualified edge.
// Latency: stable raw change -> level in 2+DEBOUNCE_CYCLES clocks; level edge -> evt_valid one clock later.
// Backpressure: token slot holds while !evt_ready; repeat edges on a pending channel merge and set sticky overflow.
// Build option: define FALL_EVT_EN to also emit falling-edge tokens (evt_edge=0).
module input_event_conditioner #(
    parameter int  CHANNELS        = 4,
    parameter int  DEBOUNCE_CYCLES = 16,
    localparam int CHAN_W          = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] level,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [CHAN_W-1:0]   evt_chan,
    output logic                evt_edge,
    output logic                overflow,
    input  logic                overflow_clr
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0]            meta_q, sync_q;
    logic [CHANNELS-1:0]            level_q, level_d;
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0]            rise_det;
    logic [CHANNELS-1:0]            pend_rise_q, pend_rise_d, clr_rise;
    logic                           evt_valid_q, evt_valid_d;
    logic [CHAN_W-1:0]              evt_chan_q, evt_chan_d;
    logic                           overflow_q, overflow_d;
    logic [CHAN_W-1:0]              sel_chan;
    logic                           any_pend, load, drop;
`ifdef FALL_EVT_EN
    logic [CHANNELS-1:0]            fall_det, pend_fall_q, pend_fall_d, clr_fall;
    logic                           evt_edge_q, evt_edge_d, sel_edge;
`endif

    // Debounce: a channel's level flips only after DEBOUNCE_CYCLES consecutive differing synced samples.
    always_comb begin
        level_d  = level_q;
        cnt_d    = '0;
        rise_det = '0;
`ifdef FALL_EVT_EN
        fall_det = '0;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            if (sync_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i]  = ~level_q[i];
                    rise_det[i] = ~level_q[i];
`ifdef FALL_EVT_EN
                    fall_det[i] = level_q[i];
`endif
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Token selection: lowest pending channel wins, rise ahead of fall on the same channel.
    always_comb begin
        sel_chan = '0;
        any_pend = 1'b0;
        clr_rise = '0;
`ifdef FALL_EVT_EN
        sel_edge = 1'b1;
        clr_fall = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pend_fall_q[i]) begin
                sel_chan = CHAN_W'(i);
                sel_edge = 1'b0;
                any_pend = 1'b1;
            end
            if (pend_rise_q[i]) begin
                sel_chan = CHAN_W'(i);
                sel_edge = 1'b1;
                any_pend = 1'b1;
            end
        end
        load = (!evt_valid_q || evt_ready) && any_pend;
        for (int i = 0; i < CHANNELS; i++) begin
            clr_rise[i] = load && sel_edge && (sel_chan == CHAN_W'(i));
            clr_fall[i] = load && !sel_edge && (sel_chan == CHAN_W'(i));
        end
`else
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pend_rise_q[i]) begin
                sel_chan = CHAN_W'(i);
                any_pend = 1'b1;
            end
        end
        load = (!evt_valid_q || evt_ready) && any_pend;
        for (int i = 0; i < CHANNELS; i++) begin
            clr_rise[i] = load && (sel_chan == CHAN_W'(i));
        end
`endif
    end

    // Pending bits, overflow and the output slot; a bit loaded this cycle may be re-armed by a fresh edge.
    always_comb begin
        pend_rise_d = (pend_rise_q & ~clr_rise) | rise_det;
        drop        = |(rise_det & pend_rise_q & ~clr_rise);
`ifdef FALL_EVT_EN
        pend_fall_d = (pend_fall_q & ~clr_fall) | fall_det;
        drop        = drop | (|(fall_det & pend_fall_q & ~clr_fall));
        evt_edge_d  = evt_edge_q;
`endif
        overflow_d  = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
        evt_valid_d = evt_valid_q;
        evt_chan_d  = evt_chan_q;
        if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end
        if (load) begin
            evt_valid_d = 1'b1;
            evt_chan_d  = sel_chan;
`ifdef FALL_EVT_EN
            evt_edge_d  = sel_edge;
`endif
        end
    end

    // State registers; reset discards all pending and presented tokens immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q      <= '0;
            sync_q      <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            pend_rise_q <= '0;
            evt_valid_q <= 1'b0;
            evt_chan_q  <= '0;
            overflow_q  <= 1'b0;
`ifdef FALL_EVT_EN
            pend_fall_q <= '0;
            evt_edge_q  <= 1'b1;
`endif
        end else begin
            meta_q      <= btn_raw;
            sync_q      <= meta_q;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            pend_rise_q <= pend_rise_d;
            evt_valid_q <= evt_valid_d;
            evt_chan_q  <= evt_chan_d;
            overflow_q  <= overflow_d;
`ifdef FALL_EVT_EN
            pend_fall_q <= pend_fall_d;
            evt_edge_q  <= evt_edge_d;
`endif
        end
    end

    assign level     = level_q;
    assign evt_valid = evt_valid_q;
    assign evt_chan  = evt_chan_q;
    assign overflow  = overflow_q;
`ifdef FALL_EVT_EN
    assign evt_edge  = evt_edge_q;
`else
    assign evt_edge  = 1'b1;
`endif

endmodule

// File: tb/tb_input_event_conditioner.sv
// Bench for input_event_conditioner: directed scenarios plus randomized traffic against a reference model.
// The model tracks synced-sample history and applies the token rules in plain sequential order.
// Every cycle compares level, evt_valid, overflow and the presented token.
module tb_input_event_conditioner;
    localparam int CH = 4;
    localparam int D  = 4;
`ifdef FALL_EVT_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] btn_raw;
    logic [CH-1:0] level;
    logic          evt_valid;
    logic          evt_ready;
    logic [1:0]    evt_chan;
    logic          evt_edge;
    logic          overflow;
    logic          overflow_clr;

    input_event_conditioner #(.CHANNELS(CH), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .level(level),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_chan(evt_chan),
        .evt_edge(evt_edge), .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int xchan[$];
    bit xedge[$];
    int xcyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [CH-1:0] rq[$];
    logic [CH-1:0] shq[$];
    logic [CH-1:0] m_level, m_pr, m_pf, m_s, m_rise, m_fall, tmpv;
    bit            mv, medge, movf, all_diff, found, m_drop;
    int            mchan;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rq.delete(); rq.push_back('0); rq.push_back('0);
            shq.delete();
            m_level = '0; m_pr = '0; m_pf = '0;
            mv = 1'b0; mchan = 0; medge = 1'b1; movf = 1'b0;
        end else begin
            m_s = rq.pop_front();
            rq.push_back(btn_raw);
            shq.push_back(m_s);
            if (shq.size() > D) void'(shq.pop_front());
            m_rise = '0; m_fall = '0;
            for (int ch = 0; ch < CH; ch++) begin
                if (shq.size() == D) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < D; k++) begin
                        tmpv = shq[k];
                        if (tmpv[ch] == m_level[ch]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        if (m_level[ch]) m_fall[ch] = 1'b1; else m_rise[ch] = 1'b1;
                        m_level[ch] = ~m_level[ch];
                    end
                end
            end
            if (!mv || evt_ready) begin
                if (mv) mv = 1'b0;
                found = 1'b0;
                for (int ch = 0; ch < CH; ch++) begin
                    if (!found) begin
                        if (m_pr[ch]) begin
                            found = 1'b1; mchan = ch; medge = 1'b1; m_pr[ch] = 1'b0;
                        end else if (FALL_EN && m_pf[ch]) begin
                            found = 1'b1; mchan = ch; medge = 1'b0; m_pf[ch] = 1'b0;
                        end
                    end
                end
                if (found) mv = 1'b1;
            end
            m_drop = 1'b0;
            for (int ch = 0; ch < CH; ch++) begin
                if (m_rise[ch]) begin
                    if (m_pr[ch]) m_drop = 1'b1; else m_pr[ch] = 1'b1;
                end
                if (FALL_EN && m_fall[ch]) begin
                    if (m_pf[ch]) m_drop = 1'b1; else m_pf[ch] = 1'b1;
                end
            end
            if (m_drop) movf = 1'b1;
            else if (overflow_clr) movf = 1'b0;
        end
    end

    task automatic compare_model();
        chk("level", level, m_level);
        chk("evt_valid", evt_valid, mv);
        chk("overflow", overflow, movf);
        if (mv) begin
            chk("evt_chan", evt_chan, mchan);
            chk("evt_edge", evt_edge, medge);
        end
    endtask

    // One clock: log a transfer happening at this edge, then compare on the falling edge.
    task automatic step();
        if (evt_valid && evt_ready) begin
            xchan.push_back(int'(evt_chan));
            xedge.push_back(evt_edge);
            xcyc.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare_model();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        xchan.delete(); xedge.delete(); xcyc.delete();
    endtask

    int n_rise1;
    logic [CH-1:0] tgt;

    initial begin
        reset = 1'b0; btn_raw = '0; evt_ready = 1'b0; overflow_clr = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_chan", evt_chan, 0);
        chk("rst_edge", evt_edge, 1);
        chk("rst_ovf", overflow, 0);
        reset = 1'b0;
        evt_ready = 1'b1;
        steps(3);

        // Single press: level after exactly 2+D clocks, token the clock after.
        btn_raw[1] = 1'b1;
        steps(5);
        chk("lat_pre", level[1], 0);
        step();
        chk("lat_level", level[1], 1);
        step();
        chk("tok_valid", evt_valid, 1);
        chk("tok_chan", evt_chan, 1);
        chk("tok_edge", evt_edge, 1);
        steps(3);

        // Bounce: 1-cycle highs every 3 clocks never qualify.
        clear_log();
        for (int i = 0; i < 30; i++) begin
            btn_raw[2] = (i % 3 == 0);
            step();
        end
        btn_raw[2] = 1'b0;
        steps(8);
        chk("bounce_level", level[2], 0);
        chk("bounce_tokens", xchan.size(), 0);

        // Simultaneous rises on ch0 and ch3 -> back-to-back tokens, lowest first.
        clear_log();
        btn_raw[0] = 1'b1; btn_raw[3] = 1'b1;
        steps(10);
        chk("pair_cnt", xchan.size(), 2);
        if (xchan.size() >= 2) begin
            chk("pair_first", xchan[0], 0);
            chk("pair_second", xchan[1], 3);
            chk("pair_gap", xcyc[1] - xcyc[0], 1);
        end

        // Backpressure and overflow on ch1.
        btn_raw[1] = 1'b0; steps(10);
        evt_ready = 1'b0;
        btn_raw[1] = 1'b1; steps(8);
        chk("bp_valid", evt_valid, 1);
        chk("bp_chan", evt_chan, 1);
        btn_raw[1] = 1'b0; steps(8);
        btn_raw[1] = 1'b1; steps(8);
`ifndef FALL_EVT_EN
        chk("ovf_first_rerise", overflow, 0);
`endif
        btn_raw[1] = 1'b0; steps(8);
        btn_raw[1] = 1'b1; steps(8);
        chk("ovf_set", overflow, 1);
        chk("bp_hold_chan", evt_chan, 1);
        clear_log();
        evt_ready = 1'b1;
        steps(8);
        n_rise1 = 0;
        for (int i = 0; i < xchan.size(); i++)
            if (xchan[i] == 1 && xedge[i]) n_rise1++;
        chk("ovf_ch1_tokens", n_rise1, 2);
        chk("ovf_sticky", overflow, 1);
        overflow_clr = 1'b1; step();
        overflow_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Asynchronous reset with a token presented and a debounce in flight.
        evt_ready = 1'b0;
        btn_raw[2] = 1'b1; steps(8);
        chk("pre_rst_valid", evt_valid, 1);
        btn_raw[0] = 1'b0; steps(3);
        #2 reset = 1'b1; btn_raw = '0;
        #1;
        chk("arst_valid", evt_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_ovf", overflow, 0);
        @(negedge clk);
        steps(2);
        reset = 1'b0;
        clear_log();
        evt_ready = 1'b1;
        steps(20);
        chk("post_rst_tokens", xchan.size(), 0);

        // Randomized traffic: slow target changes with occasional one-cycle bounces.
        tgt = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < CH; ch++) begin
                if ($urandom_range(0, 39) == 0) tgt[ch] = ~tgt[ch];
                btn_raw[ch] = tgt[ch] ^ ($urandom_range(0, 9) == 0);
            end
            evt_ready    = ($urandom_range(0, 3) != 0);
            overflow_clr = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
